// File: rtl/lcd_pkg.sv
// Shared opcodes, decoder state encoding and pixel type for the LCD command decoder.
package lcd_pkg;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CASET_P0, ST_CASET_P1, ST_CASET_P2, ST_CASET_P3,
    ST_PASET_P0, ST_PASET_P1, ST_PASET_P2, ST_PASET_P3,
    ST_RAM_B0, ST_RAM_B1,
    ST_SKIP
  } dec_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Assemble an RGB565 word from the two RAMWR bytes in arrival order.
  function automatic rgb565_t pack_pixel(input logic [7:0] first, input logic [7:0] second,
                                         input bit lo_first);
    return lo_first ? rgb565_t'({second, first}) : rgb565_t'({first, second});
  endfunction

endpackage

// File: rtl/lcd_cmd_decoder_if.sv
// Byte bus from the pixel engine: strobe, data/command select and the byte itself.
interface lcd_cmd_decoder_if;
  logic       wr_stb;
  logic       dcx;
  logic [7:0] d;

  modport master (output wr_stb, dcx, d);
  modport slave  (input  wr_stb, dcx, d);
endinterface

// File: rtl/lcd_window_cursor.sv
// Write cursor inside the column/page window: load to window origin, step in raster order with wrap.
module lcd_window_cursor (
  input  logic        clk,
  input  logic        nrst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] col_start_i,
  input  logic [15:0] col_end_i,
  input  logic [15:0] page_start_i,
  input  logic [15:0] page_end_i,
  output logic [15:0] x_o,
  output logic [15:0] y_o
);

  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;

  // Next cursor: load wins over step; end of row returns to start column, end of window wraps.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = col_start_i;
      y_d = page_start_i;
    end else if (step_i) begin
      if (x_q == col_end_i) begin
        x_d = col_start_i;
        y_d = (y_q == page_end_i) ? page_start_i : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  // Cursor registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/lcd_cmd_decoder.sv
// Display-side decoder for the D/dcx LCD command stream: tracks flags and window, emits pixels.
// Optional build macro LCD_DEC_STATS_EN adds saturating pix_count/cmd_count outputs.
module lcd_cmd_decoder
  import lcd_pkg::*;
#(
  parameter int MAX_COL  = 320,
  parameter int MAX_ROW  = 240,
  parameter bit LO_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 nrst,
  lcd_cmd_decoder_if.slave     bus,
  output logic                 disp_on,
  output logic                 sleep_out,
  output logic [15:0]          col_start,
  output logic [15:0]          col_end,
  output logic [15:0]          page_start,
  output logic [15:0]          page_end,
  output logic                 pix_valid,
  output logic [15:0]          pix_x,
  output logic [15:0]          pix_y,
  output logic [15:0]          pix_color,
  output logic                 unknown_cmd,
  output logic                 protocol_err
`ifdef LCD_DEC_STATS_EN
  ,
  output logic [31:0]          pix_count,
  output logic [15:0]          cmd_count
`endif
);

  localparam logic [15:0] COL_LAST = 16'(MAX_COL - 1);
  localparam logic [15:0] ROW_LAST = 16'(MAX_ROW - 1);

  dec_state_t  state_q, state_d;
  logic        disp_q, disp_d;
  logic        sleep_q, sleep_d;
  logic [15:0] cs_q, cs_d, ce_q, ce_d;
  logic [15:0] ps_q, ps_d, pe_q, pe_d;
  logic        pv_q, pv_d;
  logic [15:0] px_q, px_d, py_q, py_d;
  rgb565_t     pc_q, pc_d;
  logic        unk_q, unk_d;
  logic        perr_q, perr_d;
  logic [23:0] par_q, par_d;   // first three CASET/PASET bytes, oldest in the top byte
  logic [7:0]  lat_q, lat_d;   // first byte of the pixel in flight
  logic        cur_load, cur_step, swreset;
  logic [15:0] cur_x, cur_y;
  logic [15:0] new_start, new_end;

  assign new_start = par_q[23:8];
  assign new_end   = {par_q[7:0], bus.d};

  lcd_window_cursor u_cursor (
    .clk          (clk),
    .nrst         (nrst),
    .load_i       (cur_load),
    .step_i       (cur_step),
    .col_start_i  (cs_q),
    .col_end_i    (ce_q),
    .page_start_i (ps_q),
    .page_end_i   (pe_q),
    .x_o          (cur_x),
    .y_o          (cur_y)
  );

  // Decode one strobed byte: commands restart the sequence from any state, data follows the state.
  always_comb begin
    state_d  = state_q;
    disp_d   = disp_q;
    sleep_d  = sleep_q;
    cs_d     = cs_q;
    ce_d     = ce_q;
    ps_d     = ps_q;
    pe_d     = pe_q;
    pv_d     = 1'b0;
    px_d     = px_q;
    py_d     = py_q;
    pc_d     = pc_q;
    unk_d    = 1'b0;
    perr_d   = 1'b0;
    par_d    = par_q;
    lat_d    = lat_q;
    cur_load = 1'b0;
    cur_step = 1'b0;
    swreset  = 1'b0;
    if (bus.wr_stb) begin
      if (!bus.dcx) begin
        state_d = ST_IDLE;
        case (bus.d)
          CMD_NOP: ;
          CMD_SWRESET: begin
            swreset = 1'b1;
            disp_d  = 1'b0;
            sleep_d = 1'b0;
            cs_d    = '0;
            ce_d    = COL_LAST;
            ps_d    = '0;
            pe_d    = ROW_LAST;
          end
          CMD_SLPOUT:  sleep_d = 1'b1;
          CMD_DISPOFF: disp_d  = 1'b0;
          CMD_DISPON:  disp_d  = 1'b1;
          CMD_CASET:   state_d = ST_CASET_P0;
          CMD_PASET:   state_d = ST_PASET_P0;
          CMD_RAMWR: begin
            cur_load = 1'b1;
            state_d  = ST_RAM_B0;
          end
          default: begin
            unk_d   = 1'b1;
            state_d = ST_SKIP;
          end
        endcase
      end else begin
        case (state_q)
          ST_IDLE: perr_d = 1'b1;
          ST_CASET_P0: begin par_d[23:16] = bus.d; state_d = ST_CASET_P1; end
          ST_CASET_P1: begin par_d[15:8]  = bus.d; state_d = ST_CASET_P2; end
          ST_CASET_P2: begin par_d[7:0]   = bus.d; state_d = ST_CASET_P3; end
          ST_CASET_P3: begin
            if (new_start > new_end) perr_d = 1'b1;
            else begin
              cs_d = new_start;
              ce_d = new_end;
            end
            state_d = ST_IDLE;
          end
          ST_PASET_P0: begin par_d[23:16] = bus.d; state_d = ST_PASET_P1; end
          ST_PASET_P1: begin par_d[15:8]  = bus.d; state_d = ST_PASET_P2; end
          ST_PASET_P2: begin par_d[7:0]   = bus.d; state_d = ST_PASET_P3; end
          ST_PASET_P3: begin
            if (new_start > new_end) perr_d = 1'b1;
            else begin
              ps_d = new_start;
              pe_d = new_end;
            end
            state_d = ST_IDLE;
          end
          ST_RAM_B0: begin
            lat_d   = bus.d;
            state_d = ST_RAM_B1;
          end
          ST_RAM_B1: begin
            pv_d     = 1'b1;
            px_d     = cur_x;
            py_d     = cur_y;
            pc_d     = pack_pixel(lat_q, bus.d, LO_FIRST);
            cur_step = 1'b1;
            state_d  = ST_RAM_B0;
          end
          default: ;  // SKIP: parameters of an unsupported opcode are swallowed
        endcase
      end
    end
  end

  // Decoder state and all registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      disp_q  <= 1'b0;
      sleep_q <= 1'b0;
      cs_q    <= '0;
      ce_q    <= COL_LAST;
      ps_q    <= '0;
      pe_q    <= ROW_LAST;
      pv_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
      unk_q   <= 1'b0;
      perr_q  <= 1'b0;
      par_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      sleep_q <= sleep_d;
      cs_q    <= cs_d;
      ce_q    <= ce_d;
      ps_q    <= ps_d;
      pe_q    <= pe_d;
      pv_q    <= pv_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pc_q    <= pc_d;
      unk_q   <= unk_d;
      perr_q  <= perr_d;
      par_q   <= par_d;
      lat_q   <= lat_d;
    end
  end

`ifdef LCD_DEC_STATS_EN
  logic [31:0] pcnt_q;
  logic [15:0] ccnt_q;

  // Saturating activity counters; SWRESET clears them like a reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pcnt_q <= '0;
      ccnt_q <= '0;
    end else if (swreset) begin
      pcnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (pv_d && pcnt_q != '1) pcnt_q <= pcnt_q + 32'd1;
      if (bus.wr_stb && !bus.dcx && ccnt_q != '1) ccnt_q <= ccnt_q + 16'd1;
    end
  end

  assign pix_count = pcnt_q;
  assign cmd_count = ccnt_q;
`endif

  assign disp_on      = disp_q;
  assign sleep_out    = sleep_q;
  assign col_start    = cs_q;
  assign col_end      = ce_q;
  assign page_start   = ps_q;
  assign page_end     = pe_q;
  assign pix_valid    = pv_q;
  assign pix_x        = px_q;
  assign pix_y        = py_q;
  assign pix_color    = pc_q;
  assign unknown_cmd  = unk_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_lcd_cmd_decoder.sv
// Directed-vector bench for lcd_cmd_decoder (default build, LO_FIRST=1).
module tb_lcd_cmd_decoder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        disp_on, sleep_out, pix_valid, unknown_cmd, protocol_err;
  logic [15:0] col_start, col_end, page_start, page_end, pix_x, pix_y, pix_color;

  lcd_cmd_decoder_if bus ();

  lcd_cmd_decoder #(.MAX_COL(320), .MAX_ROW(240), .LO_FIRST(1'b1)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .bus          (bus),
    .disp_on      (disp_on),
    .sleep_out    (sleep_out),
    .col_start    (col_start),
    .col_end      (col_end),
    .page_start   (page_start),
    .page_end     (page_end),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_color    (pix_color),
    .unknown_cmd  (unknown_cmd),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  int pv_cnt = 0, unk_cnt = 0, perr_cnt = 0;
  logic [15:0] log_x[$], log_y[$], log_c[$];

  // Pulse monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (pix_valid) begin
      pv_cnt++;
      log_x.push_back(pix_x);
      log_y.push_back(pix_y);
      log_c.push_back(pix_color);
    end
    if (unknown_cmd)  unk_cnt++;
    if (protocol_err) perr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic dcx, input logic [7:0] d);
    @(negedge clk);
    bus.wr_stb = 1'b1;
    bus.dcx    = dcx;
    bus.d      = d;
    @(negedge clk);
    bus.wr_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int b_pv, b_unk, b_perr;
  task automatic snap();
    b_pv = pv_cnt; b_unk = unk_cnt; b_perr = perr_cnt;
  endtask

  logic [7:0] caset_w[4] = '{8'h00, 8'h00, 8'h00, 8'h01};

  initial begin
    bus.wr_stb = 1'b0; bus.dcx = 1'b0; bus.d = 8'h00;
    idle(3);
    chk("rst_disp_on", disp_on, 0);
    chk("rst_col_end", col_end, 16'd319);
    chk("rst_page_end", page_end, 16'd239);
    chk("rst_pix_valid", pix_valid, 0);
    nrst = 1'b1;
    idle(2);

    // Flag commands
    snap();
    wr(0, 8'h01); wr(0, 8'h28); wr(0, 8'h11);
    chk("slpout_flag", sleep_out, 1);
    chk("disp_still_off", disp_on, 0);
    wr(0, 8'h29);
    idle(1);
    chk("dispon_flag", disp_on, 1);
    chk("flags_no_err", perr_cnt - b_perr + unk_cnt - b_unk, 0);

    // Single pixel in a 20..40 x 0..20 window
    wr(0, 8'h2A); wr(1, 8'h00); wr(1, 8'h14); wr(1, 8'h00); wr(1, 8'h28);
    wr(0, 8'h2B); wr(1, 8'h00); wr(1, 8'h00); wr(1, 8'h00); wr(1, 8'h14);
    idle(1);
    chk("caset_start", col_start, 16'd20);
    chk("caset_end", col_end, 16'd40);
    chk("paset_end", page_end, 16'd20);
    snap();
    log_x.delete(); log_y.delete(); log_c.delete();
    wr(0, 8'h2C); wr(1, 8'h00); wr(1, 8'hF8);
    idle(2);
    chk("px1_count", pv_cnt - b_pv, 1);
    if (log_x.size() == 1) begin
      chk("px1_x", log_x[0], 16'd20);
      chk("px1_y", log_y[0], 16'd0);
      chk("px1_color", log_c[0], 16'hF800);
    end

    // 2x2 window wrap
    wr(0, 8'h2A); for (int i = 0; i < 4; i++) wr(1, caset_w[i]);
    wr(0, 8'h2B); for (int i = 0; i < 4; i++) wr(1, caset_w[i]);
    snap();
    log_x.delete(); log_y.delete(); log_c.delete();
    wr(0, 8'h2C);
    for (int i = 0; i < 5; i++) begin
      wr(1, 8'(i + 1));
      wr(1, 8'hAB);
    end
    idle(2);
    chk("wrap_count", pv_cnt - b_pv, 5);
    chk("wrap_no_err", perr_cnt - b_perr, 0);
    if (log_x.size() == 5) begin
      chk("wrap_xy0", {log_x[0], log_y[0]}, {16'd0, 16'd0});
      chk("wrap_xy1", {log_x[1], log_y[1]}, {16'd1, 16'd0});
      chk("wrap_xy2", {log_x[2], log_y[2]}, {16'd0, 16'd1});
      chk("wrap_xy3", {log_x[3], log_y[3]}, {16'd1, 16'd1});
      chk("wrap_xy4", {log_x[4], log_y[4]}, {16'd0, 16'd0});
      chk("wrap_color2", log_c[2], 16'hAB03);
    end

    // Aborted CASET, then a start>end PASET
    snap();
    wr(0, 8'h2A); wr(1, 8'h00); wr(1, 8'h05);
    wr(0, 8'h2B);
    idle(1);
    chk("abort_col", {col_start, col_end}, {16'd0, 16'd1});
    wr(1, 8'h00); wr(1, 8'h0A); wr(1, 8'h00); wr(1, 8'h05);
    idle(2);
    chk("paset_bad_err", perr_cnt - b_perr, 1);
    chk("paset_bad_keep", {page_start, page_end}, {16'd0, 16'd1});

    // Unknown opcode followed by parameters
    snap();
    wr(0, 8'h55); wr(1, 8'h12); wr(1, 8'h34);
    idle(2);
    chk("unk_pulse", unk_cnt - b_unk, 1);
    chk("unk_no_err", perr_cnt - b_perr, 0);
    chk("unk_no_pix", pv_cnt - b_pv, 0);

    // SWRESET restores the full-panel window and clears flags
    wr(0, 8'h01);
    idle(1);
    chk("swrst_win", {col_end, page_end}, {16'd319, 16'd239});
    chk("swrst_flags", {disp_on, sleep_out}, 2'b00);

    // Reset in the middle of a pixel
    wr(0, 8'h29);
    wr(0, 8'h2C); wr(1, 8'h12); wr(1, 8'h34); wr(1, 8'h56);
    idle(1);
    chk("pre_rst_color", pix_color, 16'h3412);
    nrst = 1'b0;
    idle(2);
    chk("rst2_disp", disp_on, 0);
    chk("rst2_pix", {pix_x, pix_y, pix_color}, 48'h0);
    chk("rst2_col_end", col_end, 16'd319);
    nrst = 1'b1;
    idle(1);
    snap();
    wr(1, 8'h12);
    idle(2);
    chk("post_rst_err", perr_cnt - b_perr, 1);
    chk("post_rst_no_pix", pv_cnt - b_pv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
